// File: rtl/wb_arbiter_if.sv
// Wishbone bus bundle shared by the core masters, the arbiter and the interconnect.
// Field names carry the ms (master-to-slave) / sm (slave-to-master) direction.
interface wb_bus_t #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int TGW = 4
);
    localparam int SW = DW / 8;

    logic [DW-1:0]  wb_dat_ms;
    logic [TGW-1:0] wb_tgd_ms;
    logic [AW-1:0]  wb_adr;
    logic [TGW-1:0] wb_tga;
    logic           wb_cyc;
    logic [TGW-1:0] wb_tgc;
    logic [SW-1:0]  wb_sel;
    logic           wb_stb;
    logic           wb_we;
    logic           wb_lock;

    logic [DW-1:0]  wb_dat_sm;
    logic [TGW-1:0] wb_tgd_sm;
    logic           wb_ack;
    logic           wb_err;
    logic           wb_rty;
    logic           wb_gnt;

    modport master (
        output wb_dat_ms, wb_tgd_ms, wb_adr, wb_tga, wb_cyc, wb_tgc,
               wb_sel, wb_stb, wb_we, wb_lock,
        input  wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty, wb_gnt
    );

    modport slave (
        input  wb_dat_ms, wb_tgd_ms, wb_adr, wb_tga, wb_cyc, wb_tgc,
               wb_sel, wb_stb, wb_we, wb_lock,
        output wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty, wb_gnt
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter (instruction fetch = m0, load-store = m1)
// granting whole cycles, with a watchdog that aborts transfers no slave terminates.
module wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_i,
    wb_bus_t.slave     m0_bus,
    wb_bus_t.slave     m1_bus,
    wb_bus_t.master    s_bus,
    output logic [1:0] grant_o,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   served_q, served_d;

    logic   req0, req1;
    logic   hold0, hold1;
    logic   sel0, sel1;
    logic   stb_g;
    logic   s_term;
    logic   abort;

    assign req0   = m0_bus.wb_cyc;
    assign req1   = m1_bus.wb_cyc;
    assign hold0  = m0_bus.wb_cyc | m0_bus.wb_lock;
    assign hold1  = m1_bus.wb_cyc | m1_bus.wb_lock;
    assign s_term = s_bus.wb_ack | s_bus.wb_err | s_bus.wb_rty;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_q   <= 1'b0;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            served_q <= served_d;
        end
    end

    // Until the first release, a tie goes to master 0; afterwards the master
    // that released most recently (last) loses the tie.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        served_d = served_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = (!served_q || last_q) ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!hold0) begin
                    last_d   = 1'b0;
                    served_d = 1'b1;
                    state_d  = req1 ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!hold1) begin
                    last_d   = 1'b1;
                    served_d = 1'b1;
                    state_d  = req0 ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel0    = (state_q == GNT0);
        sel1    = (state_q == GNT1);
        grant_o = {sel1, sel0};
    end

    assign stb_g = (sel0 & m0_bus.wb_stb) | (sel1 & m1_bus.wb_stb);

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

            logic [CW-1:0] wd_cnt_q, wd_cnt_d;
            logic          abort_q, abort_d;

            // Any termination, grant change, idle strobe or the abort cycle itself
            // restarts the count; reaching LIMIT unanswered schedules the abort.
            always_comb begin
                wd_cnt_d = '0;
                abort_d  = 1'b0;
                if (!abort_q && (state_d == state_q) && stb_g && !s_term) begin
                    if (wd_cnt_q == LIMIT) begin
                        abort_d = 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst_i) begin
                if (rst_i) begin
                    wd_cnt_q <= '0;
                    abort_q  <= 1'b0;
                end else begin
                    wd_cnt_q <= wd_cnt_d;
                    abort_q  <= abort_d;
                end
            end

            assign abort = abort_q;
        end else begin : g_no_wd
            assign abort = 1'b0;
        end
    endgenerate

    assign timeout_o = abort;

    // Master-to-slave forwarding; cyc/stb are suppressed during the abort cycle.
    assign s_bus.wb_dat_ms = sel0 ? m0_bus.wb_dat_ms : (sel1 ? m1_bus.wb_dat_ms : '0);
    assign s_bus.wb_tgd_ms = sel0 ? m0_bus.wb_tgd_ms : (sel1 ? m1_bus.wb_tgd_ms : '0);
    assign s_bus.wb_adr    = sel0 ? m0_bus.wb_adr    : (sel1 ? m1_bus.wb_adr    : '0);
    assign s_bus.wb_tga    = sel0 ? m0_bus.wb_tga    : (sel1 ? m1_bus.wb_tga    : '0);
    assign s_bus.wb_tgc    = sel0 ? m0_bus.wb_tgc    : (sel1 ? m1_bus.wb_tgc    : '0);
    assign s_bus.wb_sel    = sel0 ? m0_bus.wb_sel    : (sel1 ? m1_bus.wb_sel    : '0);
    assign s_bus.wb_we     = (sel0 & m0_bus.wb_we)   | (sel1 & m1_bus.wb_we);
    assign s_bus.wb_lock   = (sel0 & m0_bus.wb_lock) | (sel1 & m1_bus.wb_lock);
    assign s_bus.wb_cyc    = ((sel0 & m0_bus.wb_cyc) | (sel1 & m1_bus.wb_cyc)) & ~abort;
    assign s_bus.wb_stb    = stb_g & ~abort;

    // Slave-to-master returns; the aborted master sees err, never ack/rty.
    assign m0_bus.wb_dat_sm = sel0 ? s_bus.wb_dat_sm : '0;
    assign m0_bus.wb_tgd_sm = sel0 ? s_bus.wb_tgd_sm : '0;
    assign m0_bus.wb_ack    = sel0 & s_bus.wb_ack & ~abort;
    assign m0_bus.wb_rty    = sel0 & s_bus.wb_rty & ~abort;
    assign m0_bus.wb_err    = sel0 & (s_bus.wb_err | abort);
    assign m0_bus.wb_gnt    = sel0 & s_bus.wb_gnt;

    assign m1_bus.wb_dat_sm = sel1 ? s_bus.wb_dat_sm : '0;
    assign m1_bus.wb_tgd_sm = sel1 ? s_bus.wb_tgd_sm : '0;
    assign m1_bus.wb_ack    = sel1 & s_bus.wb_ack & ~abort;
    assign m1_bus.wb_rty    = sel1 & s_bus.wb_rty & ~abort;
    assign m1_bus.wb_err    = sel1 & (s_bus.wb_err | abort);
    assign m1_bus.wb_gnt    = sel1 & s_bus.wb_gnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (TIMEOUT=4): single master, contention/round-robin,
// lock hold, watchdog abort and restart, late ack, and asynchronous reset.
module tb_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [1:0] grant_o;
    logic       timeout_o;

    int n_checks = 0;
    int n_pass   = 0;

    wb_bus_t m0_if ();
    wb_bus_t m1_if ();
    wb_bus_t s_if ();

    wb_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .m0_bus    (m0_if),
        .m1_bus    (m1_if),
        .s_bus     (s_if),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_m0();
        m0_if.wb_dat_ms = '0; m0_if.wb_tgd_ms = '0; m0_if.wb_adr = '0; m0_if.wb_tga = '0;
        m0_if.wb_cyc = 1'b0; m0_if.wb_tgc = '0; m0_if.wb_sel = '0; m0_if.wb_stb = 1'b0;
        m0_if.wb_we = 1'b0; m0_if.wb_lock = 1'b0;
    endtask

    task automatic clr_m1();
        m1_if.wb_dat_ms = '0; m1_if.wb_tgd_ms = '0; m1_if.wb_adr = '0; m1_if.wb_tga = '0;
        m1_if.wb_cyc = 1'b0; m1_if.wb_tgc = '0; m1_if.wb_sel = '0; m1_if.wb_stb = 1'b0;
        m1_if.wb_we = 1'b0; m1_if.wb_lock = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        clr_m0();
        clr_m1();
        s_if.wb_dat_sm = '0; s_if.wb_tgd_sm = '0; s_if.wb_ack = 1'b0;
        s_if.wb_err = 1'b0; s_if.wb_rty = 1'b0; s_if.wb_gnt = 1'b0;

        // Reset state
        #2;
        check("rst_grant", grant_o, 2'b00);
        check("rst_timeout", timeout_o, 1'b0);
        check("rst_scyc", s_if.wb_cyc, 1'b0);
        check("rst_m0_ack", m0_if.wb_ack, 1'b0);
        check("rst_m1_err", m1_if.wb_err, 1'b0);
        tick(); tick();
        rst_i = 1'b0;
        $display("txn reset done");

        // Single master m1, slave acks two cycles after the request
        tick();
        m1_if.wb_cyc = 1'b1; m1_if.wb_stb = 1'b1; m1_if.wb_adr = 32'h1000;
        #1;
        check("t1_grant_pre", grant_o, 2'b00);
        check("t1_ack_pre", m1_if.wb_ack, 1'b0);
        tick(); #1;
        check("t1_grant", grant_o, 2'b10);
        check("t1_adr", s_if.wb_adr, 32'h1000);
        check("t1_scyc", s_if.wb_cyc, 1'b1);
        check("t1_ack_early", m1_if.wb_ack, 1'b0);
        tick();
        s_if.wb_ack = 1'b1; s_if.wb_dat_sm = 32'hCAFE_F00D;
        #1;
        check("t1_m1_ack", m1_if.wb_ack, 1'b1);
        check("t1_m1_dat", m1_if.wb_dat_sm, 32'hCAFE_F00D);
        check("t1_m0_ack", m0_if.wb_ack, 1'b0);
        check("t1_m0_dat", m0_if.wb_dat_sm, 32'h0);
        tick();
        s_if.wb_ack = 1'b0;
        clr_m1();
        #1;
        check("t1_grant_hold", grant_o, 2'b10);
        tick(); #1;
        check("t1_grant_idle", grant_o, 2'b00);
        $display("txn single_master done");

        // Contention straight after the first release-free period: m0 wins
        tick();
        m0_if.wb_cyc = 1'b1; m0_if.wb_adr = 32'hA0;
        m1_if.wb_cyc = 1'b1; m1_if.wb_adr = 32'hB0;
        tick(); #1;
        check("t2_grant_m0", grant_o, 2'b01);
        check("t2_adr_m0", s_if.wb_adr, 32'hA0);
        tick();
        m0_if.wb_cyc = 1'b0;
        #1;
        check("t2_grant_keep", grant_o, 2'b01);
        tick(); #1;
        check("t2_handover", grant_o, 2'b10);
        check("t2_adr_m1", s_if.wb_adr, 32'hB0);
        m1_if.wb_cyc = 1'b0;
        tick(); #1;
        check("t2_idle", grant_o, 2'b00);
        m0_if.wb_cyc = 1'b1; m1_if.wb_cyc = 1'b1;
        tick(); #1;
        check("t2_rr_m0", grant_o, 2'b01);
        m0_if.wb_cyc = 1'b0; m1_if.wb_cyc = 1'b0;
        tick(); tick(); #1;
        check("t2_idle2", grant_o, 2'b00);
        m0_if.wb_cyc = 1'b1; m1_if.wb_cyc = 1'b1;
        tick(); #1;
        check("t2_rr_m1", grant_o, 2'b10);
        clr_m0(); clr_m1();
        tick(); tick(); #1;
        check("t2_idle3", grant_o, 2'b00);
        $display("txn contention done");

        // Lock: m0 keeps the bus with cyc=0 lock=1 while m1 waits
        m0_if.wb_cyc = 1'b1; m0_if.wb_stb = 1'b1; m0_if.wb_lock = 1'b1;
        tick();
        s_if.wb_ack = 1'b1;
        #1;
        check("t3_grant", grant_o, 2'b01);
        check("t3_m0_ack", m0_if.wb_ack, 1'b1);
        check("t3_slock", s_if.wb_lock, 1'b1);
        tick();
        s_if.wb_ack = 1'b0;
        m0_if.wb_cyc = 1'b0; m0_if.wb_stb = 1'b0;
        m1_if.wb_cyc = 1'b1;
        #1;
        check("t3_lock_c1", grant_o, 2'b01);
        check("t3_scyc_locked", s_if.wb_cyc, 1'b0);
        tick(); #1;
        check("t3_lock_c2", grant_o, 2'b01);
        tick(); #1;
        check("t3_lock_c3", grant_o, 2'b01);
        tick();
        m0_if.wb_lock = 1'b0;
        #1;
        check("t3_unlock", grant_o, 2'b01);
        tick(); #1;
        check("t3_m1_gnt", grant_o, 2'b10);
        clr_m1();
        tick(); tick(); #1;
        check("t3_idle", grant_o, 2'b00);
        $display("txn lock done");

        // Watchdog: m1 strobes, slave silent; abort in S+4, then again in S+9
        m1_if.wb_cyc = 1'b1; m1_if.wb_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check("t4_wait_to", timeout_o, 1'b0);
            check("t4_wait_err", m1_if.wb_err, 1'b0);
        end
        tick();
        s_if.wb_ack = 1'b1;
        #1;
        check("t4_timeout", timeout_o, 1'b1);
        check("t4_err", m1_if.wb_err, 1'b1);
        check("t4_ack_drop", m1_if.wb_ack, 1'b0);
        check("t4_scyc", s_if.wb_cyc, 1'b0);
        check("t4_sstb", s_if.wb_stb, 1'b0);
        check("t4_grant", grant_o, 2'b10);
        tick();
        s_if.wb_ack = 1'b0;
        #1;
        check("t4_to_pulse", timeout_o, 1'b0);
        check("t4_err_pulse", m1_if.wb_err, 1'b0);
        check("t4_scyc_back", s_if.wb_cyc, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t4_rewait", timeout_o, 1'b0);
        end
        tick(); #1;
        check("t4_timeout2", timeout_o, 1'b1);
        clr_m1();
        tick(); tick(); #1;
        check("t4_idle", grant_o, 2'b00);
        $display("txn watchdog done");

        // Late ack in the 4th waiting cycle: no abort
        m1_if.wb_cyc = 1'b1; m1_if.wb_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t5_wait_err", m1_if.wb_err, 1'b0);
        end
        tick();
        s_if.wb_ack = 1'b1;
        #1;
        check("t5_ack", m1_if.wb_ack, 1'b1);
        check("t5_err", m1_if.wb_err, 1'b0);
        check("t5_to", timeout_o, 1'b0);
        tick();
        s_if.wb_ack = 1'b0;
        clr_m1();
        #1;
        check("t5_to_after", timeout_o, 1'b0);
        check("t5_err_after", m1_if.wb_err, 1'b0);
        tick(); tick();
        $display("txn late_ack done");

        // Asynchronous reset mid-transfer
        m0_if.wb_cyc = 1'b1; m0_if.wb_stb = 1'b1;
        tick(); #1;
        check("t6_grant", grant_o, 2'b01);
        check("t6_scyc", s_if.wb_cyc, 1'b1);
        #1;
        rst_i = 1'b1;
        #1;
        check("t6_rst_grant", grant_o, 2'b00);
        check("t6_rst_scyc", s_if.wb_cyc, 1'b0);
        check("t6_rst_sstb", s_if.wb_stb, 1'b0);
        clr_m0();
        tick();
        rst_i = 1'b0;
        m1_if.wb_cyc = 1'b1;
        #1;
        check("t6_post_idle", grant_o, 2'b00);
        tick(); #1;
        check("t6_post_m1", grant_o, 2'b10);
        clr_m1();
        tick();
        $display("txn reset_mid done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
